// File: rtl/regs_pkg.sv
// ----------------------------------------------------------------------------
// regs_pkg : GPR file geometry shared by regfile, issue logic and writeback.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package regs_pkg;
  localparam int GPR_AW = 5;
  localparam int GPR_N  = 32;
  localparam int GPR_DW = 64;
endpackage

`default_nettype wire

// File: rtl/rr_pick2.sv
// ----------------------------------------------------------------------------
// rr_pick2 : combinational two-winner round-robin picker, distinct addresses.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_pick2 #(
  parameter int NREQ = 4,
  parameter int AW   = 5,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]    valid,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [PW-1:0]      rr_ptr,
  output logic [NREQ-1:0]    grant0,
  output logic [NREQ-1:0]    grant1,
  output logic [PW-1:0]      idx0,
  output logic [PW-1:0]      idx1,
  output logic               any0,
  output logic               any1
);

  logic [AW-1:0] addr_a [NREQ];
  logic [PW:0]   sum;
  logic [PW-1:0] j;
  logic [AW-1:0] addr0;

  generate
    for (genvar i = 0; i < NREQ; i++) begin : g_addr
      assign addr_a[i] = addr[i*AW +: AW];
    end
  endgenerate

  always_comb begin
    grant0 = '0;
    grant1 = '0;
    idx0   = '0;
    idx1   = '0;
    any0   = 1'b0;
    any1   = 1'b0;
    sum    = '0;
    j      = '0;
    addr0  = '0;
    for (int k = 0; k < NREQ; k++) begin
      // Explicit wrap keeps the scan correct when NREQ is not a power of two.
      sum = {1'b0, rr_ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      j = sum[PW-1:0];
      if (valid[j]) begin
        if (!any0) begin
          any0      = 1'b1;
          idx0      = j;
          addr0     = addr_a[j];
          grant0[j] = 1'b1;
        end else if (!any1 && (addr_a[j] != addr0)) begin
          any1      = 1'b1;
          idx1      = j;
          grant1[j] = 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/regs_wb_arbiter.sv
// ----------------------------------------------------------------------------
// regs_wb_arbiter : 2-port GPR writeback arbiter with per-register busy board.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module regs_wb_arbiter
  import regs_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = GPR_AW,
  parameter int DW   = GPR_DW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    reqValid,
  output logic [NREQ-1:0]    reqReady,
  input  logic [NREQ*AW-1:0] reqAddr,
  input  logic [NREQ*DW-1:0] reqData,
  input  logic               reserveEn,
  input  logic [AW-1:0]      reserveAddr,
  output logic [GPR_N-1:0]   busy,
  output logic               err,
  output logic               writeEn0,
  output logic [AW-1:0]      writeAddr0,
  output logic [DW-1:0]      writeData0,
  output logic               writeEn1,
  output logic [AW-1:0]      writeAddr1,
  output logic [DW-1:0]      writeData1
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]  grant0, grant1;
  logic [PW-1:0]    idx0, idx1;
  logic             any0, any1;
  logic [AW-1:0]    addr_a [NREQ];
  logic [DW-1:0]    data_a [NREQ];

  logic             we0_q, we0_d, we1_q, we1_d;
  logic [AW-1:0]    wa0_q, wa0_d, wa1_q, wa1_d;
  logic [DW-1:0]    wd0_q, wd0_d, wd1_q, wd1_d;
  logic [GPR_N-1:0] busy_q, busy_d;
  logic             err_q, err_d;
  logic             clr_hit;

  generate
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign addr_a[i] = reqAddr[i*AW +: AW];
      assign data_a[i] = reqData[i*DW +: DW];
    end
  endgenerate

  rr_pick2 #(
    .NREQ (NREQ),
    .AW   (AW),
    .PW   (PW)
  ) u_pick (
    .valid  (reqValid),
    .addr   (reqAddr),
    .rr_ptr (rr_ptr_q),
    .grant0 (grant0),
    .grant1 (grant1),
    .idx0   (idx0),
    .idx1   (idx1),
    .any0   (any0),
    .any1   (any1)
  );

  assign reqReady = grant0 | grant1;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (int'(p) == NREQ-1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (any1)      rr_ptr_d = ptr_inc(idx1);
    else if (any0) rr_ptr_d = ptr_inc(idx0);
    we0_d = any0;
    wa0_d = addr_a[idx0];
    wd0_d = data_a[idx0];
    we1_d = any1;
    wa1_d = addr_a[idx1];
    wd1_d = data_a[idx1];
  end

  // Clears track the registered write (same edge the regfile updates); a set wins.
  always_comb begin
    busy_d  = busy_q;
    clr_hit = (we0_q && (wa0_q == reserveAddr)) || (we1_q && (wa1_q == reserveAddr));
    if (we0_q) busy_d[wa0_q] = 1'b0;
    if (we1_q) busy_d[wa1_q] = 1'b0;
    if (reserveEn) busy_d[reserveAddr] = 1'b1;
    err_d = err_q | (reserveEn & busy_q[reserveAddr] & ~clr_hit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      we0_q    <= 1'b0;
      wa0_q    <= '0;
      wd0_q    <= '0;
      we1_q    <= 1'b0;
      wa1_q    <= '0;
      wd1_q    <= '0;
      busy_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      we0_q    <= we0_d;
      wa0_q    <= wa0_d;
      wd0_q    <= wd0_d;
      we1_q    <= we1_d;
      wa1_q    <= wa1_d;
      wd1_q    <= wd1_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign writeEn0   = we0_q;
  assign writeAddr0 = wa0_q;
  assign writeData0 = wd0_q;
  assign writeEn1   = we1_q;
  assign writeAddr1 = wa1_q;
  assign writeData1 = wd1_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_regs_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_regs_wb_arbiter : directed + random bench with write scoreboard and model.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_regs_wb_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 5;
  localparam int DW   = 64;

  typedef struct packed {
    logic          en;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    v;
  logic [AW-1:0]      a [NREQ];
  logic [DW-1:0]      d [NREQ];
  logic [NREQ*AW-1:0] reqAddr_s;
  logic [NREQ*DW-1:0] reqData_s;
  logic [NREQ-1:0]    reqReady;
  logic               rsv_en;
  logic [AW-1:0]      rsv_addr;
  logic [31:0]        busy;
  logic               err;
  logic               writeEn0, writeEn1;
  logic [AW-1:0]      writeAddr0, writeAddr1;
  logic [DW-1:0]      writeData0, writeData1;

  int checks = 0;
  int errors = 0;

  int          m_ptr;
  logic [31:0] m_busy;
  logic        m_err;
  logic        mw_en [2];
  logic [AW-1:0] mw_addr [2];
  wr_t         exp_q[$];

  logic [DW-1:0] rf [32];
  int            wr_cnt [32];
  logic [DW-1:0] r7_log[$];
  logic [NREQ-1:0] rdy, vb;
  int              wait_c [NREQ];

  always #5 clk = ~clk;

  always_comb begin
    reqAddr_s = '0;
    reqData_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      reqAddr_s[i*AW +: AW] = a[i];
      reqData_s[i*DW +: DW] = d[i];
    end
  end

  regs_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .reqValid    (v),
    .reqReady    (reqReady),
    .reqAddr     (reqAddr_s),
    .reqData     (reqData_s),
    .reserveEn   (rsv_en),
    .reserveAddr (rsv_addr),
    .busy        (busy),
    .err         (err),
    .writeEn0    (writeEn0),
    .writeAddr0  (writeAddr0),
    .writeData0  (writeData0),
    .writeEn1    (writeEn1),
    .writeAddr1  (writeAddr1),
    .writeData1  (writeData1)
  );

  // Register file image driven only by what the DUT actually writes.
  always @(posedge clk) begin
    if (writeEn0) begin
      rf[writeAddr0]     <= writeData0;
      wr_cnt[writeAddr0] <= wr_cnt[writeAddr0] + 1;
      if (writeAddr0 == 5'd7) r7_log.push_back(writeData0);
    end
    if (writeEn1) begin
      rf[writeAddr1]     <= writeData1;
      wr_cnt[writeAddr1] <= wr_cnt[writeAddr1] + 1;
      if (writeAddr1 == 5'd7) r7_log.push_back(writeData1);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic void model_pick(output int g0, output int g1);
    int j;
    g0 = -1;
    g1 = -1;
    for (int k = 0; k < NREQ; k++) begin
      j = (m_ptr + k) % NREQ;
      if (v[j]) begin
        if (g0 < 0) g0 = j;
        else if (g1 < 0 && a[j] != a[g0]) g1 = j;
      end
    end
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    m_busy = '0;
    m_err = 1'b0;
    mw_en[0] = 1'b0;
    mw_en[1] = 1'b0;
    mw_addr[0] = '0;
    mw_addr[1] = '0;
    exp_q.delete();
  endtask

  // One clock: check grants, predict writes, advance, then score outputs.
  task automatic tick(output logic [NREQ-1:0] r);
    int g0, g1;
    logic [31:0] nb;
    logic hit;
    wr_t e0, e1, o0, o1;
    model_pick(g0, g1);
    r = '0;
    if (g0 >= 0) r[g0] = 1'b1;
    if (g1 >= 0) r[g1] = 1'b1;
    #1;
    chk("reqReady", 64'(reqReady), 64'(r));
    e0 = '0;
    e1 = '0;
    if (g0 >= 0) begin e0.en = 1'b1; e0.addr = a[g0]; e0.data = d[g0]; end
    if (g1 >= 0) begin e1.en = 1'b1; e1.addr = a[g1]; e1.data = d[g1]; end
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    nb = m_busy;
    hit = 1'b0;
    for (int p = 0; p < 2; p++) begin
      if (mw_en[p]) begin
        nb[mw_addr[p]] = 1'b0;
        if (mw_addr[p] == rsv_addr) hit = 1'b1;
      end
    end
    if (rsv_en) begin
      if (m_busy[rsv_addr] && !hit) m_err = 1'b1;
      nb[rsv_addr] = 1'b1;
    end
    @(posedge clk);
    #1;
    m_busy = nb;
    mw_en[0] = e0.en; mw_addr[0] = e0.addr;
    mw_en[1] = e1.en; mw_addr[1] = e1.addr;
    if (g1 >= 0) m_ptr = (g1 + 1) % NREQ;
    else if (g0 >= 0) m_ptr = (g0 + 1) % NREQ;
    rsv_en = 1'b0;
    if (g0 >= 0) v[g0] = 1'b0;
    if (g1 >= 0) v[g1] = 1'b0;
    o0 = exp_q.pop_front();
    o1 = exp_q.pop_front();
    chk("writeEn0", 64'(writeEn0), 64'(o0.en));
    if (o0.en) begin
      chk("writeAddr0", 64'(writeAddr0), 64'(o0.addr));
      chk("writeData0", writeData0, o0.data);
    end
    chk("writeEn1", 64'(writeEn1), 64'(o1.en));
    if (o1.en) begin
      chk("writeAddr1", 64'(writeAddr1), 64'(o1.addr));
      chk("writeData1", writeData1, o1.data);
    end
    chk("busy", 64'(busy), 64'(m_busy));
    chk("err", 64'(err), 64'(m_err));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    v = '0;
    rsv_en = 1'b0;
    rsv_addr = '0;
    for (int i = 0; i < NREQ; i++) begin a[i] = '0; d[i] = '0; wait_c[i] = 0; end
    for (int i = 0; i < 32; i++) begin rf[i] = '0; wr_cnt[i] = 0; end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_writeEn0", 64'(writeEn0), 64'd0);
    chk("rst_writeEn1", 64'(writeEn1), 64'd0);
    chk("rst_writeAddr0", 64'(writeAddr0), 64'd0);
    chk("rst_writeData0", writeData0, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);

    // Reset while a grant to r3 sits in the output registers.
    rsv_en = 1'b1; rsv_addr = 5'd3;
    tick(rdy);
    v[0] = 1'b1; a[0] = 5'd3; d[0] = 64'h1111;
    tick(rdy);
    #2;
    rst_n = 1'b0;
    #1;
    v = '0;
    chk("midrst_writeEn0", 64'(writeEn0), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    repeat (3) tick(rdy);
    chk("midrst_r3_writes", 64'(wr_cnt[3]), 64'd0);

    // Four distinct requesters, two per cycle.
    v = 4'hF;
    for (int i = 0; i < NREQ; i++) begin a[i] = AW'(i + 1); d[i] = 64'hA0 + 64'(i); end
    tick(rdy);
    chk("rr_c1_addr0", 64'(writeAddr0), 64'd1);
    chk("rr_c1_addr1", 64'(writeAddr1), 64'd2);
    tick(rdy);
    chk("rr_c2_addr0", 64'(writeAddr0), 64'd3);
    chk("rr_c2_addr1", 64'(writeAddr1), 64'd4);
    tick(rdy);

    // Same-address pair: second one deferred.
    v = 4'b0111;
    a[0] = 5'd7; d[0] = 64'h70;
    a[1] = 5'd7; d[1] = 64'h71;
    a[2] = 5'd9; d[2] = 64'h92;
    tick(rdy);
    chk("same_c1_addr1", 64'(writeAddr1), 64'd9);
    tick(rdy);
    chk("same_c2_data0", writeData0, 64'h71);
    tick(rdy);
    chk("r7_count", 64'(r7_log.size()), 64'd2);
    if (r7_log.size() == 2) begin
      chk("r7_first", r7_log[0], 64'h70);
      chk("r7_second", r7_log[1], 64'h71);
    end

    // Busy clears on the edge the regfile is written.
    rsv_en = 1'b1; rsv_addr = 5'd5;
    tick(rdy);
    v[1] = 1'b1; a[1] = 5'd5; d[1] = 64'hDEADBEEF;
    tick(rdy);
    chk("busy5_pending", 64'(busy[5]), 64'd1);
    tick(rdy);
    chk("busy5_cleared", 64'(busy[5]), 64'd0);
    chk("r5_readback", rf[5], 64'hDEADBEEF);

    // Reserve racing a clear, then a genuine double reserve.
    rsv_en = 1'b1; rsv_addr = 5'd5;
    tick(rdy);
    v[0] = 1'b1; a[0] = 5'd5; d[0] = 64'h55;
    tick(rdy);
    rsv_en = 1'b1; rsv_addr = 5'd5;
    tick(rdy);
    chk("race_busy5", 64'(busy[5]), 64'd1);
    chk("race_err", 64'(err), 64'd0);
    rsv_en = 1'b1; rsv_addr = 5'd5;
    tick(rdy);
    chk("dbl_err", 64'(err), 64'd1);
    repeat (2) tick(rdy);
    chk("err_sticky", 64'(err), 64'd1);

    // Random traffic; per-requester addresses stay distinct so two grants are always possible.
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!v[i] && ($urandom_range(1, 0) == 1)) begin
          v[i] = 1'b1;
          a[i] = {2'(i), 3'($urandom_range(7, 0))};
          d[i] = {$urandom, $urandom};
        end
      end
      if ($urandom_range(3, 0) == 0) begin
        rsv_en = 1'b1;
        rsv_addr = 5'($urandom_range(31, 0));
      end
      vb = v;
      tick(rdy);
      for (int i = 0; i < NREQ; i++) begin
        if (vb[i] && !rdy[i]) wait_c[i]++;
        else wait_c[i] = 0;
        chk("starve", 64'(wait_c[i] <= NREQ/2), 64'd1);
      end
      if (writeEn0 && writeEn1)
        chk("dual_same_addr", 64'(writeAddr0 != writeAddr1), 64'd1);
    end

    v = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("final_rst_err", 64'(err), 64'd0);
    chk("final_rst_busy", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
